// File: rtl/xyolo_read_stage_pkg.sv
// Shared types and width helpers for the xyolo read stage.
package xyolo_read_stage_pkg;

    // Control FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BIAS   = 2'd1,
        ST_FETCH  = 2'd2,
        ST_STREAM = 2'd3
    } xr_state_t;

    // Width of one weight row: every MAC of every vector unit gets one element.
    function automatic int unsigned calc_wrow_w(input int unsigned n_vect,
                                                input int unsigned n_macs,
                                                input int unsigned datapath_w);
        return n_vect * n_macs * datapath_w;
    endfunction

    // Width of the bias vector: one element per vector unit.
    function automatic int unsigned calc_bias_w(input int unsigned n_vect,
                                                input int unsigned datapath_w);
        return n_vect * datapath_w;
    endfunction

    // Byte stride between consecutive databus words.
    function automatic int unsigned calc_byte_incr(input int unsigned databus_w);
        return databus_w / 8;
    endfunction

endpackage

// File: rtl/xyolo_int_addrgen.sv
// Nested-loop buffer read address generator: iter periods of per reads,
// stepping incr inside a period and shift between periods.
module xyolo_int_addrgen #(
    parameter int unsigned AW = 10,
    parameter int unsigned CW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          en,
    input  logic [CW-1:0] iter,
    input  logic [CW-1:0] per,
    input  logic [CW-1:0] shift,
    input  logic [CW-1:0] incr,
    output logic [AW-1:0] addr,
    output logic          valid,
    output logic          done
);

    logic [CW-1:0] i_cnt;
    logic [CW-1:0] j_cnt;
    logic [AW-1:0] base;

    // Loop counters; addr/valid describe the read issued this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            done  <= 1'b0;
            addr  <= '0;
            base  <= '0;
            i_cnt <= '0;
            j_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                i_cnt <= '0;
                j_cnt <= '0;
                base  <= '0;
                addr  <= '0;
                valid <= (iter != '0) && (per != '0);
                done  <= (iter == '0) || (per == '0);
            end else if (valid && en) begin
                if (j_cnt == per - CW'(1)) begin
                    j_cnt <= '0;
                    base  <= base + shift[AW-1:0];
                    addr  <= base + shift[AW-1:0];
                    if (i_cnt == iter - CW'(1)) begin
                        valid <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        i_cnt <= i_cnt + CW'(1);
                    end
                end else begin
                    j_cnt <= j_cnt + CW'(1);
                    addr  <= addr + incr[AW-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/xyolo_int_mem2p.sv
// Two-port buffer primitive: one synchronous write port, one registered read port.
module xyolo_int_mem2p #(
    parameter int unsigned W  = 256,
    parameter int unsigned AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [0:(1<<AW)-1];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port, one cycle latency.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/xyolo_read_stage.sv
// xyolo read stage: fetch optional bias plus a weight block over the databus
// into a local buffer, then stream weight rows to the xyolo vector units.
// Optional macro XYOLO_READ_STALL_CNT_EN adds a 32-bit databus stall counter.
module xyolo_read_stage
    import xyolo_read_stage_pkg::*;
#(
    parameter int unsigned DATAPATH_W = 32,
    parameter int unsigned DATABUS_W  = 256,
    parameter int unsigned N_VECT     = 4,
    parameter int unsigned N_MACS     = 2,
    parameter int unsigned IO_ADDR_W  = 32,
    parameter int unsigned MEM_ADDR_W = 10
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                global_run,
    output logic                                done,
    input  logic [IO_ADDR_W-1:0]                ext_addr,
    input  logic [MEM_ADDR_W:0]                 n_words,
    input  logic                                bias_en,
    input  logic [MEM_ADDR_W:0]                 rd_iter,
    input  logic [MEM_ADDR_W:0]                 rd_per,
    input  logic [MEM_ADDR_W:0]                 rd_shift,
    input  logic [MEM_ADDR_W:0]                 rd_incr,
    input  logic                                databus_ready,
    output logic                                databus_valid,
    output logic [IO_ADDR_W-1:0]                databus_addr,
    input  logic [DATABUS_W-1:0]                databus_rdata,
`ifdef XYOLO_READ_STALL_CNT_EN
    output logic [31:0]                         stall_cnt,
`endif
    output logic [N_VECT*N_MACS*DATAPATH_W-1:0] flow_out_weight,
    output logic [N_VECT*DATAPATH_W-1:0]        flow_out_bias,
    output logic                                flow_out_valid
);

    localparam int unsigned WROW_W    = calc_wrow_w(N_VECT, N_MACS, DATAPATH_W);
    localparam int unsigned BIAS_W    = calc_bias_w(N_VECT, DATAPATH_W);
    localparam int unsigned BYTE_INCR = calc_byte_incr(DATABUS_W);
    localparam int unsigned CNT_W     = MEM_ADDR_W + 1;

    xr_state_t state_q;
    xr_state_t state_d;

    logic [CNT_W-1:0]      n_words_q;
    logic [CNT_W-1:0]      rd_iter_q;
    logic [CNT_W-1:0]      rd_per_q;
    logic [CNT_W-1:0]      rd_shift_q;
    logic [CNT_W-1:0]      rd_incr_q;
    logic [CNT_W-1:0]      xfer_cnt_q;

    logic                  wr_en_q;
    logic [MEM_ADDR_W-1:0] wr_addr_q;
    logic [WROW_W-1:0]     wr_data_q;
    logic [WROW_W-1:0]     mem_q;

    logic                  ag_start_q;
    logic                  ag_valid;
    logic                  ag_done;
    logic [MEM_ADDR_W-1:0] ag_addr;
    logic                  rd_v1_q;
    logic                  fin_q;

    logic xfer_c;
    logic last_word_c;
    logic stream_empty_c;
    logic stream_fin_c;
    logic run_acc_c;
    logic bias_xfer_c;
    logic fetch_xfer_c;
    logic enter_stream_c;
    logic req_d;
    logic done_d;

    assign xfer_c         = databus_valid && databus_ready;
    assign last_word_c    = (xfer_cnt_q + CNT_W'(1)) == n_words_q;
    assign stream_empty_c = (rd_iter_q == '0) || (rd_per_q == '0);
    // Stream ends once the generator has finished and the last read has
    // left the buffer stage; the output register then shows the final row.
    assign stream_fin_c   = (fin_q || ag_done || stream_empty_c) && !rd_v1_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (global_run) begin
                    if (bias_en) begin
                        state_d = ST_BIAS;
                    end else if (n_words != '0) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end
            end
            ST_BIAS: begin
                if (xfer_c) begin
                    state_d = (n_words_q != '0) ? ST_FETCH : ST_STREAM;
                end
            end
            ST_FETCH: begin
                if (xfer_c && last_word_c) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (stream_fin_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath-control decode.
    always_comb begin
        run_acc_c      = 1'b0;
        bias_xfer_c    = 1'b0;
        fetch_xfer_c   = 1'b0;
        enter_stream_c = 1'b0;
        req_d          = 1'b0;
        done_d         = 1'b0;
        run_acc_c      = (state_q == ST_IDLE) && global_run;
        bias_xfer_c    = (state_q == ST_BIAS) && xfer_c;
        fetch_xfer_c   = (state_q == ST_FETCH) && xfer_c;
        enter_stream_c = (state_q != ST_STREAM) && (state_d == ST_STREAM);
        req_d          = (state_d == ST_BIAS) || (state_d == ST_FETCH);
        done_d         = (state_d == ST_IDLE);
    end

    // Config latch, databus request, bias capture and buffer write staging.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done          <= 1'b1;
            databus_valid <= 1'b0;
            databus_addr  <= '0;
            flow_out_bias <= '0;
            n_words_q     <= '0;
            rd_iter_q     <= '0;
            rd_per_q      <= '0;
            rd_shift_q    <= '0;
            rd_incr_q     <= '0;
            xfer_cnt_q    <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            ag_start_q    <= 1'b0;
        end else begin
            done          <= done_d;
            databus_valid <= req_d;
            ag_start_q    <= enter_stream_c;
            wr_en_q       <= fetch_xfer_c;
            if (run_acc_c) begin
                n_words_q    <= n_words;
                rd_iter_q    <= rd_iter;
                rd_per_q     <= rd_per;
                rd_shift_q   <= rd_shift;
                rd_incr_q    <= rd_incr;
                xfer_cnt_q   <= '0;
                databus_addr <= ext_addr;
            end else if (xfer_c) begin
                databus_addr <= databus_addr + IO_ADDR_W'(BYTE_INCR);
            end
            if (bias_xfer_c) begin
                flow_out_bias <= databus_rdata[BIAS_W-1:0];
            end
            if (fetch_xfer_c) begin
                wr_addr_q  <= xfer_cnt_q[MEM_ADDR_W-1:0];
                wr_data_q  <= databus_rdata;
                xfer_cnt_q <= xfer_cnt_q + CNT_W'(1);
            end
        end
    end

    // Read pipeline: buffer output stage then output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_v1_q         <= 1'b0;
            fin_q           <= 1'b0;
            flow_out_valid  <= 1'b0;
            flow_out_weight <= '0;
        end else begin
            rd_v1_q        <= ag_valid;
            fin_q          <= (state_q == ST_STREAM) && (fin_q || ag_done);
            flow_out_valid <= rd_v1_q;
            if (rd_v1_q) begin
                flow_out_weight <= mem_q;
            end
        end
    end

`ifdef XYOLO_READ_STALL_CNT_EN
    // Saturating count of cycles the databus request waits for ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (run_acc_c) begin
            stall_cnt <= '0;
        end else if (databus_valid && !databus_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

    xyolo_int_addrgen #(
        .AW (MEM_ADDR_W),
        .CW (CNT_W)
    ) u_addrgen (
        .clk   (clk),
        .rst   (rst),
        .start (ag_start_q),
        .en    (1'b1),
        .iter  (rd_iter_q),
        .per   (rd_per_q),
        .shift (rd_shift_q),
        .incr  (rd_incr_q),
        .addr  (ag_addr),
        .valid (ag_valid),
        .done  (ag_done)
    );

    xyolo_int_mem2p #(
        .W  (WROW_W),
        .AW (MEM_ADDR_W)
    ) u_buf (
        .clk   (clk),
        .we    (wr_en_q),
        .waddr (wr_addr_q),
        .wdata (wr_data_q),
        .re    (ag_valid),
        .raddr (ag_addr),
        .rdata (mem_q)
    );

endmodule

// File: tb/tb_xyolo_read_stage.sv
// Bench for xyolo_read_stage: random databus contents, directed configurations,
// expected requests and rows computed from a simple memory/loop model.
module tb_xyolo_read_stage;

    localparam int unsigned CW = 11;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         global_run;
    logic         done;
    logic [31:0]  ext_addr;
    logic [CW-1:0] n_words;
    logic         bias_en;
    logic [CW-1:0] rd_iter;
    logic [CW-1:0] rd_per;
    logic [CW-1:0] rd_shift;
    logic [CW-1:0] rd_incr;
    logic         databus_ready;
    logic         databus_valid;
    logic [31:0]  databus_addr;
    logic [255:0] databus_rdata;
    logic [255:0] flow_out_weight;
    logic [127:0] flow_out_bias;
    logic         flow_out_valid;
`ifdef XYOLO_READ_STALL_CNT_EN
    logic [31:0]  stall_cnt;
`endif

    always #5 clk = ~clk;

    xyolo_read_stage dut (
        .clk             (clk),
        .rst             (rst),
        .global_run      (global_run),
        .done            (done),
        .ext_addr        (ext_addr),
        .n_words         (n_words),
        .bias_en         (bias_en),
        .rd_iter         (rd_iter),
        .rd_per          (rd_per),
        .rd_shift        (rd_shift),
        .rd_incr         (rd_incr),
        .databus_ready   (databus_ready),
        .databus_valid   (databus_valid),
        .databus_addr    (databus_addr),
        .databus_rdata   (databus_rdata),
`ifdef XYOLO_READ_STALL_CNT_EN
        .stall_cnt       (stall_cnt),
`endif
        .flow_out_weight (flow_out_weight),
        .flow_out_bias   (flow_out_bias),
        .flow_out_valid  (flow_out_valid)
    );

    // External memory: 16 consecutive 32-byte words starting at base_addr.
    logic [255:0] ext_words [0:15];
    logic [31:0]  base_addr = 32'h0;
    logic [31:0]  word_off;
    always_comb begin
        word_off      = (databus_addr - base_addr) >> 5;
        databus_rdata = (word_off < 32'd16) ? ext_words[word_off[3:0]] : '0;
    end

    // Ready pattern: mode 0 always ready, mode 1 ready one cycle in three.
    int rdy_mode  = 0;
    int rdy_phase = 0;
    initial begin
        databus_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) begin
                databus_ready = 1'b1;
            end else begin
                rdy_phase     = (rdy_phase + 1) % 3;
                databus_ready = (rdy_phase == 0);
            end
        end
    end

    // Observed traffic, sampled mid-cycle.
    logic [31:0]  req_q [$];
    logic [255:0] row_q [$];
    int           stall_cycles = 0;
    int           stab_err     = 0;
    int           valid_cycles = 0;
    logic         prev_stall   = 1'b0;
    logic [31:0]  prev_addr    = 32'h0;
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall && (!databus_valid || databus_addr != prev_addr)) stab_err++;
            if (databus_valid) valid_cycles++;
            if (databus_valid && databus_ready) req_q.push_back(databus_addr);
            if (databus_valid && !databus_ready) stall_cycles++;
            if (flow_out_valid) row_q.push_back(flow_out_weight);
            prev_stall = databus_valid && !databus_ready;
            prev_addr  = databus_addr;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Reference model state: buffer image and current bias.
    logic [255:0] mbuf   [0:1023];
    bit           mknown [0:1023];
    logic [127:0] exp_bias = '0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_words();
        base_addr = $urandom & 32'h7FFF_FFE0;
        for (int k = 0; k < 16; k++) begin
            ext_words[k] = {$urandom, $urandom, $urandom, $urandom,
                            $urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic do_test(input string name, input bit b, input int nw, input int it,
                           input int pr, input int sh, input int inc, input int rmode,
                           input bit poke);
        int off;
        int n_req;
        int cyc;
        int idx;
        int a;
        bit poked;
        load_words();
        rdy_mode = rmode;
        req_q.delete();
        row_q.delete();
        stall_cycles = 0;
        stab_err     = 0;
        ext_addr   = base_addr;
        bias_en    = b;
        n_words    = CW'(nw);
        rd_iter    = CW'(it);
        rd_per     = CW'(pr);
        rd_shift   = CW'(sh);
        rd_incr    = CW'(inc);
        global_run = 1'b1;
        @(posedge clk); #1;
        global_run = 1'b0;
        check({name, "_busy"}, 256'(done), 256'(0));
        poked = 1'b0;
        cyc   = 0;
        while (!done && cyc < 2000) begin
            global_run = 1'b0;
            if (poke && !poked && row_q.size() > 0) begin
                global_run = 1'b1;
                ext_addr   = base_addr + 32'h1000;
                bias_en    = 1'b1;
                poked      = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        global_run = 1'b0;
        check({name, "_done"}, 256'(done), 256'(1));
        repeat (4) begin
            @(posedge clk); #1;
        end

        off = b ? 1 : 0;
        if (b) exp_bias = ext_words[0][127:0];
        for (int k = 0; k < nw; k++) begin
            mbuf[k % 1024]   = ext_words[off + k];
            mknown[k % 1024] = 1'b1;
        end
        n_req = off + nw;
        check({name, "_reqcnt"}, 256'(req_q.size()), 256'(n_req));
        for (int k = 0; k < n_req && k < req_q.size(); k++) begin
            check($sformatf("%s_req%0d", name, k), 256'(req_q[k]), 256'(base_addr + 32'(32 * k)));
        end
        check({name, "_bias"}, 256'(flow_out_bias), 256'(exp_bias));
        check({name, "_rowcnt"}, 256'(row_q.size()), 256'(it * pr));
        idx = 0;
        for (int i = 0; i < it; i++) begin
            for (int j = 0; j < pr; j++) begin
                a = (i * sh + j * inc) % 1024;
                if (idx < row_q.size() && mknown[a]) begin
                    check($sformatf("%s_row%0d", name, idx), row_q[idx], mbuf[a]);
                end
                idx++;
            end
        end
        check({name, "_stall_stable"}, 256'(stab_err), 256'(0));
`ifdef XYOLO_READ_STALL_CNT_EN
        check({name, "_stall_cnt"}, 256'(stall_cnt), 256'(stall_cycles));
`endif
    endtask

    initial begin
        int cyc;
        for (int k = 0; k < 1024; k++) mknown[k] = 1'b0;
        global_run = 1'b0;
        ext_addr   = '0;
        n_words    = '0;
        bias_en    = 1'b0;
        rd_iter    = '0;
        rd_per     = '0;
        rd_shift   = '0;
        rd_incr    = '0;
        for (int k = 0; k < 16; k++) ext_words[k] = '0;

        // Reset values.
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done",   256'(done),            256'(1));
        check("rst_valid",  256'(databus_valid),   256'(0));
        check("rst_addr",   256'(databus_addr),    256'(0));
        check("rst_weight", flow_out_weight,       256'(0));
        check("rst_bias",   256'(flow_out_bias),   256'(0));
        check("rst_fov",    256'(flow_out_valid),  256'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Bias plus four words, linear stream, always ready.
        do_test("basic", 1'b1, 4, 1, 4, 0, 1, 0, 1'b0);
        // Same transfer with a stalling slave.
        do_test("stall", 1'b1, 4, 1, 4, 0, 1, 1, 1'b0);
        // Strided/shifted pattern: rows 0,2,1,3.
        do_test("stride", 1'b0, 3, 2, 2, 1, 2, 0, 1'b0);

        // Nothing to fetch and nothing to stream.
        req_q.delete();
        row_q.delete();
        valid_cycles = 0;
        bias_en    = 1'b0;
        n_words    = '0;
        rd_iter    = CW'(3);
        rd_per     = '0;
        global_run = 1'b1;
        @(posedge clk); #1;
        global_run = 1'b0;
        check("empty_busy", 256'(done), 256'(0));
        @(posedge clk); #1;
        check("empty_done", 256'(done), 256'(1));
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("empty_valid_cycles", 256'(valid_cycles), 256'(0));
        check("empty_rows", 256'(row_q.size()), 256'(0));

        // Reset after two of six fetch transfers, then restart.
        load_words();
        rdy_mode = 0;
        req_q.delete();
        row_q.delete();
        ext_addr   = base_addr;
        bias_en    = 1'b0;
        n_words    = CW'(6);
        rd_iter    = CW'(1);
        rd_per     = CW'(6);
        rd_shift   = '0;
        rd_incr    = CW'(1);
        global_run = 1'b1;
        @(posedge clk); #1;
        global_run = 1'b0;
        cyc = 0;
        while (req_q.size() < 2 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("abort_two_xfers", 256'(req_q.size()), 256'(2));
        rst = 1'b1;
        #1;
        check("abort_valid", 256'(databus_valid), 256'(0));
        check("abort_done",  256'(done),          256'(1));
        check("abort_bias",  256'(flow_out_bias), 256'(0));
        exp_bias  = '0;
        mknown[0] = 1'b0;
        mknown[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_test("restart", 1'b0, 6, 1, 6, 0, 1, 0, 1'b0);

        // global_run while streaming must be ignored.
        do_test("poke", 1'b0, 4, 1, 4, 0, 1, 0, 1'b1);

        // A few random configurations.
        for (int t = 0; t < 3; t++) begin
            do_test($sformatf("rand%0d", t), 1'($urandom_range(0, 1)),
                    int'($urandom_range(1, 14)), int'($urandom_range(1, 3)),
                    int'($urandom_range(1, 4)), int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 5)), int'($urandom_range(0, 1)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/xyolo_read_stage.md
Name: xyolo_read_stage

Overview:
- Upstream neighbour of the YOLO write/compute stage.
- Fetches one optional bias word and a block of weight words from external memory over a single databus read port, and stores the weights in an internal buffer.
- Then streams them out one weight row per cycle, with the bias held stable, as flow_out_weight/flow_out_bias for the xyolo vector units.
- Sequencing is fetch-then-stream, started by global_run.

Parameters:
- DATAPATH_W, 32, width of one weight/bias element
- DATABUS_W, 256, databus word width; must equal N_VECT*N_MACS*DATAPATH_W
- N_VECT, 4, number of xyolo units fed
- N_MACS, 2, MACs per xyolo unit
- IO_ADDR_W, 32, external byte address width
- MEM_ADDR_W, 10, weight buffer address width (depth 2^MEM_ADDR_W rows)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- global_run  in  1  start pulse; config sampled this cycle
- done  out  1  high when idle, nothing pending
- ext_addr  in  IO_ADDR_W  byte address of first word (bias if enabled)
- n_words  in  MEM_ADDR_W+1  weight words to fetch
- bias_en  in  1  fetch one bias word before weights
- rd_iter, rd_per, rd_shift, rd_incr  in  MEM_ADDR_W+1 each  streaming address pattern
- databus_ready  in  1  slave accept; rdata valid same cycle
- databus_valid  out  1  read request
- databus_addr  out  IO_ADDR_W  request byte address
- databus_rdata  in  DATABUS_W  read data
- flow_out_weight  out  N_VECT*N_MACS*DATAPATH_W  current weight row
- flow_out_bias  out  N_VECT*DATAPATH_W  bias vector
- flow_out_valid  out  1  flow_out_weight holds a fresh row this cycle

Behaviour:
- FSM states: IDLE, BIAS, FETCH, STREAM.
- Reset values: state=IDLE, done=1, databus_valid=0, databus_addr=0, flow_out_weight=0, flow_out_bias=0, flow_out_valid=0.
- IDLE:
  - global_run latches config and sets done=0, addr=ext_addr.
  - Next state: BIAS if bias_en, else FETCH.
  - global_run outside IDLE is ignored.
- Databus handshake:
  - databus_valid held high with a stable address until databus_ready.
  - Transfer occurs when valid&ready; rdata captured that cycle.
  - Address then advances by DATABUS_W/8.
  - One request outstanding; valid may stay high back-to-back.
- BIAS:
  - On transfer, flow_out_bias <= rdata[N_VECT*DATAPATH_W-1:0]; go to FETCH.
  - Bias keeps its previous value when bias_en=0.
- FETCH:
  - Transfer k (0-based) writes rdata into buffer row k mod 2^MEM_ADDR_W; the write is registered, so it lands 1 cycle after transfer.
  - After n_words transfers, go to STREAM.
  - n_words=0: FETCH is skipped with no requests.
  - n_words>depth: writes wrap and later rows overwrite earlier ones.
- STREAM:
  - Nested loop. For i in 0..rd_iter-1: for j in 0..rd_per-1: addr = base + j*rd_incr; after each period base += rd_shift; base starts at 0.
  - Addresses are truncated to MEM_ADDR_W.
  - One buffer read per cycle, no stalls.
  - Buffer read latency 1, plus output register: flow_out_weight/flow_out_valid are 2 cycles after the read is issued.
  - rd_iter=0 or rd_per=0: no reads.
  - After the last read, flow_out_valid pulses for the final row, then state=IDLE; done=1 the cycle after the last flow_out_valid.
  - flow_out_weight holds its last value when not valid.
- First stream read occurs the cycle after the final FETCH write lands, so read-after-write is safe.
- Reset mid-operation: asynchronous return to reset values, including databus_valid dropping immediately. Buffer contents are not cleared.

Optional Feature:
- Macro: XYOLO_READ_STALL_CNT_EN.
- Defined: adds output stall_cnt, 32 bits. It resets to 0, clears on an accepted global_run, and increments each cycle databus_valid=1 and databus_ready=0. It saturates at all-ones.
- Undefined: no port, no logic.

Decomposition:
- Shared package/header:
  - FSM state encodings (2-bit)
  - derived widths WROW_W=N_VECT*N_MACS*DATAPATH_W and BIAS_W=N_VECT*DATAPATH_W
  - byte increment DATABUS_W/8
- Sub-module xyolo_int_addrgen holds the iter/per/shift/incr counters: start, enable, addr, valid, done.
- The buffer uses the existing 2-port memory primitive.

Test Plan:
- bias_en=1, n_words=4, ready always 1, rd_iter=1, rd_per=4, rd_incr=1 -> 5 requests at ext_addr+0,32,...,128; bias = low 128 bits of word 0; 4 flow_out_valid rows equal to words 1..4 in order; done rises afterwards.
- Same transfer with ready toggling 1-of-3 cycles -> databus_addr/valid stable while stalled; identical output rows; stall_cnt = stall cycles when XYOLO_READ_STALL_CNT_EN is defined.
- n_words=3, rd_iter=2, rd_per=2, rd_incr=2, rd_shift=1 -> row order 0,2,1,3; row 3 is stale/unwritten data (checked as don't-care).
- n_words=0 and rd_per=0 -> no databus_valid, no flow_out_valid, done back to 1 within 2 cycles of global_run.
- Assert rst during FETCH after 2 of 6 transfers -> databus_valid=0 and done=1 immediately; a new global_run restarts from ext_addr.
- global_run pulsed during STREAM -> ignored; row sequence and count unchanged.
